// File: rtl/cache_port_arbiter_if.sv
// Bundles the requester-side and cache-side req/gnt/rvalid signals of the
// cache port arbiter. The arbiter uses the slave modport. The surrounding
// masters and the cache (or a testbench standing in for them) use the master modport.
interface cache_port_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // requester side
  logic [NUM_MASTERS-1:0]            m_req_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_be_i;
  logic [NUM_MASTERS-1:0]            m_gnt_o;
  logic [NUM_MASTERS-1:0]            m_rvalid_o;
  logic [DATA_WIDTH-1:0]             m_rdata_o;
  logic [NUM_MASTERS-1:0]            m_err_o;

  // cache side
  logic                              c_req_o;
  logic [ADDR_WIDTH-1:0]             c_addr_o;
  logic [DATA_WIDTH-1:0]             c_wdata_o;
  logic                              c_we_o;
  logic [BE_WIDTH-1:0]               c_be_o;
  logic                              c_gnt_i;
  logic                              c_rvalid_i;
  logic [DATA_WIDTH-1:0]             c_rdata_i;
  logic                              c_err_i;

  modport slave (
    input  m_req_i, m_addr_i, m_wdata_i, m_we_i, m_be_i,
    input  c_gnt_i, c_rvalid_i, c_rdata_i, c_err_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
    output c_req_o, c_addr_o, c_wdata_o, c_we_o, c_be_o
  );

  modport master (
    output m_req_i, m_addr_i, m_wdata_i, m_we_i, m_be_i,
    output c_gnt_i, c_rvalid_i, c_rdata_i, c_err_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
    input  c_req_o, c_addr_o, c_wdata_o, c_we_o, c_be_o
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Shares the single core port of the blocking data cache between NUM_MASTERS
// requesters. Only one transaction is in flight at a time. The winning request
// is latched and held on the cache port until it is granted. The response is
// then steered back to the owner.
// Optional feature: define CACHE_ARB_FIXED_PRIO_EN for fixed priority, where
// the lowest index wins. By default arbitration is round-robin.
module cache_port_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cache_port_arbiter_if.slave    bus,
  output logic                   busy_o,
  output logic [2:0]             owner_o
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic [BE_WIDTH-1:0]   r_be;
  logic                  w_any_req;
  logic [2:0]            w_win;
  logic                  w_latch;

`ifdef CACHE_ARB_FIXED_PRIO_EN
  // Fixed-priority winner: the last assignment is the lowest requesting index.
  always_comb begin
    w_any_req = |bus.m_req_i;
    w_win     = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (bus.m_req_i[i]) w_win = 3'(i);
  end
`else
  logic [2:0] r_ptr;

  // Round-robin winner: the search starts at r_ptr+1. Looping downwards lets the
  // nearest requester after the pointer make the last assignment.
  always_comb begin
    w_any_req = |bus.m_req_i;
    w_win     = '0;
    for (int i = NUM_MASTERS; i >= 1; i--)
      if (bus.m_req_i[(int'(r_ptr) + i) % NUM_MASTERS])
        w_win = 3'((int'(r_ptr) + i) % NUM_MASTERS);
  end

  // The pointer follows the last winner. The reset value makes master 0 the first to win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ptr <= 3'(NUM_MASTERS - 1);
    else if (w_latch) r_ptr <= w_win;
  end
`endif

  // State and owner registers.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples
  // the values from before the clock edge, whatever order the statements run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) r_owner <= w_win;
    end
  end

  // Payload capture when a request is latched.
  // NOTE: the payload has no reset. It reaches the cache port only while in
  // ISSUE, and it is always written before the FSM enters ISSUE.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_addr  <= bus.m_addr_i [int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
      r_wdata <= bus.m_wdata_i[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
      r_we    <= bus.m_we_i   [w_win];
      r_be    <= bus.m_be_i   [int'(w_win)*BE_WIDTH +: BE_WIDTH];
    end
  end

  // Next state and every output. A stray gnt or rvalid is ignored, because the
  // steering is enabled only in the state where that signal is expected.
  // NOTE: every output gets a default first, so no path through the case
  // statement can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_latch        = 1'b0;
    bus.c_req_o    = 1'b0;
    bus.c_addr_o   = '0;
    bus.c_wdata_o  = '0;
    bus.c_we_o     = 1'b0;
    bus.c_be_o     = '0;
    bus.m_gnt_o    = '0;
    bus.m_rvalid_o = '0;
    bus.m_err_o    = '0;
    bus.m_rdata_o  = '0;
    busy_o         = (r_state != IDLE);
    owner_o        = (r_state == IDLE) ? 3'd0 : r_owner;

    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_latch     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.c_req_o   = 1'b1;
        bus.c_addr_o  = r_addr;
        bus.c_wdata_o = r_wdata;
        bus.c_we_o    = r_we;
        bus.c_be_o    = r_be;
        for (int i = 0; i < NUM_MASTERS; i++)
          bus.m_gnt_o[i] = bus.c_gnt_i && (r_owner == 3'(i));
        if (bus.c_gnt_i) w_state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        bus.m_rdata_o = bus.c_rdata_i;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          bus.m_rvalid_o[i] = bus.c_rvalid_i && (r_owner == 3'(i));
          bus.m_err_o[i]    = bus.c_rvalid_i && bus.c_err_i && (r_owner == 3'(i));
        end
        // The next transaction is arbitrated in the response cycle, so there is no idle bubble.
        if (bus.c_rvalid_i) begin
          if (w_any_req) begin
            w_latch     = 1'b1;
            w_state_nxt = ISSUE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
Shares the single core-side port of the direct-mapped data cache between NUM_MASTERS requesters (e.g. instruction fetch, data LSU, debug), using the PULPino req/gnt/rvalid protocol on both sides. The cache is blocking with one outstanding transaction, so the arbiter sequences exactly one transaction at a time. It latches the winning request, holds it on the cache port until the cache grants it, then steers the response back to the owner. It sits between the core/debug masters and the cache's core_* port.

Parameters:
NUM_MASTERS, 2, number of requesters; legal range 2..8
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
m_req_i  in  NUM_MASTERS  per-master request
m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master k uses slice k
m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  flattened write data
m_we_i  in  NUM_MASTERS  per-master write enable
m_be_i  in  NUM_MASTERS*DATA_WIDTH/8  flattened byte enables
m_gnt_o  out  NUM_MASTERS  one-hot grant pulse
m_rvalid_o  out  NUM_MASTERS  one-hot response valid
m_rdata_o  out  DATA_WIDTH  response data, shared by all masters
m_err_o  out  NUM_MASTERS  response error, qualified by m_rvalid_o
c_req_o  out  1  cache request
c_addr_o  out  ADDR_WIDTH  cache address
c_wdata_o  out  DATA_WIDTH  cache write data
c_we_o  out  1  cache write enable
c_be_o  out  DATA_WIDTH/8  cache byte enables
c_gnt_i  in  1  cache grant
c_rvalid_i  in  1  cache response valid
c_rdata_i  in  DATA_WIDTH  cache read data
c_err_i  in  1  cache error
busy_o  out  1  high whenever state is not IDLE
owner_o  out  3  index of the current owner; 0 in IDLE

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, all c_* outputs 0, m_gnt_o/m_rvalid_o/m_err_o 0, busy_o 0, owner_o 0. The round-robin pointer resets to NUM_MASTERS-1, so master 0 has first priority.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE: if any m_req_i is set, select the winner by round-robin, starting the search at pointer+1 modulo NUM_MASTERS. Register the winner's addr/wdata/we/be into the payload register. Set owner to the winner and pointer to the winner. Go to ISSUE.
- ISSUE: c_req_o=1 and c_* driven from the payload register, stable until granted. m_gnt_o[owner] = c_gnt_i, combinational. On c_gnt_i go to WAIT_RESP and drop c_req_o on the next cycle.
- WAIT_RESP: c_req_o=0. m_rvalid_o[owner] = c_rvalid_i. m_rdata_o = c_rdata_i. m_err_o[owner] = c_err_i & c_rvalid_i.
  - On c_rvalid_i with no pending m_req_i, go to IDLE.
  - On c_rvalid_i with a pending m_req_i, arbitrate in that same cycle (same rule as IDLE) and go straight to ISSUE, with no bubble cycle.
- Latency: master req at cycle 0 gives c_req_o at cycle 1. Master gnt equals the cache gnt cycle. Master rvalid equals the cache rvalid cycle, with no added delay.
- A master whose m_req_i stays high while another master owns the port waits, and gets no gnt.
- The request is sampled once at latch. If a master changes addr or drops req after being latched, this has no effect. The latched transaction completes and its rvalid is still delivered.
- c_gnt_i or c_rvalid_i outside the expected state (IDLE, or c_rvalid_i in ISSUE) is ignored. No master sees a pulse.
- Reset asserted mid-transaction returns the block to reset values immediately. Any in-flight response is dropped.
- m_gnt_o and m_rvalid_o are each at most one-hot in every cycle.

Optional Feature:
CACHE_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins. The round-robin pointer is not implemented.
- Undefined (default): round-robin as described above.

Test Plan:
- Single read: master 1 reads 0x0000_0104; cache gnt at cycle 2, rvalid at cycle 5 with 0xDEAD_BEEF -> c_addr_o=0x104, m_gnt_o=2'b10 at cycle 2, m_rvalid_o=2'b10 and m_rdata_o=0xDEAD_BEEF at cycle 5, m_rvalid_o[0] never set.
- Simultaneous requests: masters 0 and 1 request at the same cycle after reset -> master 0 served first, then master 1 issued in the same cycle as master 0's rvalid. Three more contended rounds -> grant order 0,1,0,1.
- Write passthrough: master 0 writes wdata 0x1122_3344, be 4'b0011, addr 0x40 -> c_we_o=1, c_be_o=4'b0011, c_wdata_o=0x1122_3344 held stable through 3 cycles of c_gnt_i=0.
- Error steering: c_err_i=1 with c_rvalid_i for master 1 -> m_err_o=2'b10 for exactly one cycle, m_err_o[0]=0.
- Reset mid-op: drop rst_n in WAIT_RESP, then apply c_rvalid_i after release -> no m_rvalid_o pulse, busy_o=0, next request is granted to master 0.
- Fixed priority: with CACHE_ARB_FIXED_PRIO_EN defined, both masters request continuously for 4 transactions -> all 4 granted to master 0.
